uart_sample_rx: RTL and testbench
=================================

Name: uart_sample_rx

Overview:
- Receiving end of the ADC sample UART link: deserialises the 8N1 (optional parity) stream and reassembles 12-bit ADC samples.
- Sample framing on the wire: byte 0 = {4'b0, sample[11:8]}, byte 1 = sample[7:0].
- Sits in the capture FPGA (or bench harness) and presents one validated 12-bit sample per pulse to downstream logic.
- Detects bit-level errors (false start, framing, parity) and pairing errors (bad high byte, inter-byte timeout).

Parameters:
- BAUD_RATE, 3, clock cycles per bit; minimum 3; use the shared baud generator constants (3 = 8 Mbaud at 24 MHz).
- PARITY, 0, 0 = no parity bit; 1 = one even-parity bit between data and stop.
- GAP_TIMEOUT, 64, clock cycles allowed between the high byte's stop-bit sample and the next start-bit detection.

Ports:
- clk  input  1  system clock, 24 MHz nominal.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- sample  output  12  last assembled sample; holds until the next valid sample.
- sample_valid  output  1  one-cycle pulse; sample is valid in the same cycle.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- parity_error  output  1  one-cycle pulse: parity mismatch (PARITY=1 only).
- sync_error  output  1  one-cycle pulse: high byte[7:4]!=0, or inter-byte timeout.
- busy  output  1  high from start-bit detection until stop-bit sample.

Behaviour:
- Reset (reset=0, async): all outputs 0; bit FSM in IDLE; pair FSM in HI_WAIT; stored nibble 0; synchroniser flops set to 1.
- rx passes through a 2-flop synchroniser, giving 2 cycles of fixed latency. All timing below is relative to the synchronised rx.
- Bit FSM states: IDLE, START, DATA, PAR, STOP, RECOVER.
- IDLE -> START on the first low sample; clear the bit counter; set busy.
- START: wait BAUD_RATE/2 (floor) cycles, then sample.
  - Low: go to DATA.
  - High: false start; go to IDLE silently with no pulse.
- DATA: sample every BAUD_RATE cycles, 8 bits, LSB first, into a shift register.
  - After bit 7: go to PAR if PARITY=1, else STOP.
- PAR: sample after BAUD_RATE cycles. Mismatch against even parity of the data byte flags a parity error.
- STOP: sample after BAUD_RATE cycles; clear busy in the cycle after this sample.
  - High and no parity error: the byte is accepted; go to IDLE.
  - Low: pulse framing_error; go to RECOVER.
  - High with parity error: pulse parity_error; go to IDLE.
  - In both error cases the byte is discarded and the pair FSM is forced to HI_WAIT.
- RECOVER: wait for rx high, then go to IDLE. This prevents a break condition from being read as a new start.
- An accepted byte is delivered to the pair FSM in the cycle after the stop sample.
- Back-to-back frames with no idle gap are supported. IDLE can detect a start bit ≥1 cycle after the stop sample.
- Pair FSM states: HI_WAIT, LO_WAIT.
- HI_WAIT, on an accepted byte:
  - byte[7:4]==0: store byte[3:0] as the nibble; go to LO_WAIT.
  - Otherwise: pulse sync_error; stay in HI_WAIT.
- LO_WAIT, on an accepted byte (any value): sample <= {nibble, byte}; pulse sample_valid in the same cycle; go to HI_WAIT.
- Gap timer: counts in LO_WAIT while the bit FSM is IDLE.
  - Reaching GAP_TIMEOUT: pulse sync_error; go to HI_WAIT.
  - A start detection clears the timer.
- Total latency: sample_valid rises 1 cycle after the low byte's stop-bit sample.
- Only one error pulse is raised per byte. Precedence: framing > parity > sync.
- Reset asserted mid-frame aborts immediately. After release the block resumes at IDLE/HI_WAIT; a partially received pair is lost.

Test Plan:
1. BAUD_RATE=3, PARITY=0: send 0x0A, then 0xBC back-to-back -> one sample_valid pulse with sample=0xABC; no error pulses.
2. Send 0xF1, then 0x03, 0x45 -> sync_error pulse after 0xF1, then sample=0x345; sample stays 0x345 afterwards.
3. Send 0x05 with stop bit driven low for 2 bit times, then line high, then 0x01, 0x23 -> framing_error once, then sample=0x123.
4. PARITY=1: send 0x0A with odd parity bit -> parity_error, no sample. Then correct 0x0A, 0xBC -> sample=0xABC.
5. Send 0x07, then idle 100 cycles (GAP_TIMEOUT=64), then 0x08, 0x9F -> sync_error at gap expiry, then sample=0x89F (0x07 discarded).
6. rx low glitch of 1 cycle -> no busy beyond START, no pulses. Reset pulsed low during bit 4 of a high byte -> all outputs 0; next 0x0F, 0xFF -> sample=0xFFF.

Source files
------------

// File: rtl/uart_sample_rx.sv
// Receiver for the ADC sample UART link: 8N1 (optional even parity) deserialiser
// followed by a pairing stage that rebuilds 12-bit samples from {high nibble, low byte}.
module uart_sample_rx #(
  parameter int unsigned BAUD_RATE   = 3,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        framing_error,
  output logic        parity_error,
  output logic        sync_error,
  output logic        busy
);

  localparam int unsigned HalfBit = BAUD_RATE / 2;
  localparam int unsigned CntW    = $clog2(BAUD_RATE);
  localparam int unsigned GapW    = $clog2(GAP_TIMEOUT + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_RATE - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StRecover
  } bit_state_e;

  typedef enum logic {
    PairHi,
    PairLo
  } pair_state_e;

  // Synchroniser flops preset high so reset never looks like a start bit.
  logic rx_meta, rx_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit-level deserialiser
  bit_state_e      bit_state_q, bit_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_err_q, par_err_d;
  logic            busy_q, busy_d;
  logic            start_det;
  logic            byte_ok;
  logic            frame_err;
  logic            par_fail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_state_q <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_state_q <= bit_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    bit_state_d = bit_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    busy_d      = busy_q;
    start_det   = 1'b0;
    byte_ok     = 1'b0;
    frame_err   = 1'b0;
    par_fail    = 1'b0;

    unique case (bit_state_q)
      StIdle: begin
        if (!rx_sync) begin
          start_det   = 1'b1;
          cnt_d       = '0;
          bit_idx_d   = '0;
          par_err_d   = 1'b0;
          busy_d      = 1'b1;
          bit_state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_sync) begin
            // Start bit vanished before mid-bit: treat as noise.
            busy_d      = 1'b0;
            bit_state_d = StIdle;
          end else begin
            bit_state_d = StData;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            bit_state_d = (PARITY != 0) ? StPar : StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPar: begin
        if (cnt_q == BitLast) begin
          cnt_d       = '0;
          par_err_d   = (rx_sync != (^shift_q));
          bit_state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (!rx_sync) begin
            frame_err   = 1'b1;
            bit_state_d = StRecover;
          end else if (par_err_q) begin
            par_fail    = 1'b1;
            bit_state_d = StIdle;
          end else begin
            byte_ok     = 1'b1;
            bit_state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecover: begin
        // A held-low line (break) must not be taken as a fresh start bit.
        if (rx_sync) begin
          bit_state_d = StIdle;
        end
      end
      default: begin
        bit_state_d = StIdle;
      end
    endcase
  end

  // Sample pairing, gap timer and registered outputs
  pair_state_e     pair_q, pair_d;
  logic [3:0]      nibble_q, nibble_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [11:0]     sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            framing_q, framing_d;
  logic            parity_q, parity_d;
  logic            sync_q, sync_d;
  logic            gap_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_q    <= PairHi;
      nibble_q  <= '0;
      gap_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      framing_q <= 1'b0;
      parity_q  <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      nibble_q  <= nibble_d;
      gap_q     <= gap_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      framing_q <= framing_d;
      parity_q  <= parity_d;
      sync_q    <= sync_d;
    end
  end

  // Gap timer only runs while waiting for the low byte with the line idle.
  always_comb begin
    gap_d      = gap_q;
    gap_expire = 1'b0;
    if (pair_q != PairLo || start_det) begin
      gap_d = '0;
    end else if (bit_state_q == StIdle) begin
      if (gap_q == GapLast) begin
        gap_expire = 1'b1;
        gap_d      = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_comb begin
    pair_d    = pair_q;
    nibble_d  = nibble_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    framing_d = frame_err;
    parity_d  = par_fail;
    sync_d    = 1'b0;

    if (frame_err || par_fail) begin
      pair_d = PairHi;
    end else if (byte_ok) begin
      case (pair_q)
        PairHi: begin
          if (shift_q[7:4] == 4'h0) begin
            nibble_d = shift_q[3:0];
            pair_d   = PairLo;
          end else begin
            sync_d = 1'b1;
          end
        end
        PairLo: begin
          sample_d = {nibble_q, shift_q};
          valid_d  = 1'b1;
          pair_d   = PairHi;
        end
        default: begin
          pair_d = PairHi;
        end
      endcase
    end else if (gap_expire) begin
      sync_d = 1'b1;
      pair_d = PairHi;
    end
  end

  assign sample        = sample_q;
  assign sample_valid  = valid_q;
  assign framing_error = framing_q;
  assign parity_error  = parity_q;
  assign sync_error    = sync_q;
  assign busy          = busy_q;

  // At most one of the result pulses per cycle.
  a_one_pulse: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({sample_valid, framing_error, parity_error, sync_error}));

endmodule

// File: tb/tb_uart_sample_rx.sv
// Bench for uart_sample_rx: directed scenarios plus random frame streams scored
// against a byte-level model of the sample pairing protocol.
module tb_uart_sample_rx;

  localparam int BAUD = 3;
  localparam int GAP  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [11:0] d0_sample, d1_sample;
  logic        d0_valid, d0_fe, d0_pe, d0_se, d0_busy;
  logic        d1_valid, d1_fe, d1_pe, d1_se, d1_busy;

  always #5 clk = ~clk;

  uart_sample_rx #(.BAUD_RATE(BAUD), .PARITY(0), .GAP_TIMEOUT(GAP)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .sample       (d0_sample),
    .sample_valid (d0_valid),
    .framing_error(d0_fe),
    .parity_error (d0_pe),
    .sync_error   (d0_se),
    .busy         (d0_busy)
  );

  uart_sample_rx #(.BAUD_RATE(BAUD), .PARITY(1), .GAP_TIMEOUT(GAP)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .sample       (d1_sample),
    .sample_valid (d1_valid),
    .framing_error(d1_fe),
    .parity_error (d1_pe),
    .sync_error   (d1_se),
    .busy         (d1_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Observation state, updated once per clock just after the active edge.
  int          cyc = 0;
  int          busy_cnt, multi_cnt, sv_cyc0, stop_cyc;
  int          fe0, pe0, se0, fe1, pe1, se1;
  logic [11:0] got0[$];
  logic [11:0] got1[$];

  // Random transaction list and model expectations.
  logic [7:0]  tb_byte[$];
  int          tb_kind[$];  // 0 good, 1 stop low, 2 bad parity
  int          tb_gap[$];
  logic [11:0] exp_q[$];
  int          exp_fe, exp_pe, exp_se;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (d0_valid) begin
        got0.push_back(d0_sample);
        sv_cyc0 = cyc;
      end
      if (d1_valid) got1.push_back(d1_sample);
      fe0 += int'(d0_fe);
      pe0 += int'(d0_pe);
      se0 += int'(d0_se);
      fe1 += int'(d1_fe);
      pe1 += int'(d1_pe);
      se1 += int'(d1_se);
      busy_cnt += int'(d0_busy);
      if ((int'(d0_valid) + int'(d0_fe) + int'(d0_pe) + int'(d0_se) > 1) ||
          (int'(d1_valid) + int'(d1_fe) + int'(d1_pe) + int'(d1_se) > 1)) multi_cnt++;
    end
  endtask

  task automatic clear_obs();
    got0.delete();
    got1.delete();
    fe0 = 0; pe0 = 0; se0 = 0;
    fe1 = 0; pe1 = 0; se1 = 0;
    busy_cnt = 0; multi_cnt = 0; sv_cyc0 = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx    = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_obs();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_bad,
                            input bit frame_bad);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    if (par_en) begin
      rx = (^b) ^ par_bad;
      tick(BAUD);
    end
    stop_cyc = cyc;
    if (frame_bad) begin
      rx = 1'b0;
      tick(2 * BAUD);
    end
    rx = 1'b1;
    tick(BAUD);
  endtask

  task automatic gen(input bit par_en, input int n);
    logic [7:0] b;
    int         r;
    tb_byte.delete();
    tb_kind.delete();
    tb_gap.delete();
    for (int i = 0; i < n; i++) begin
      b = ($urandom_range(0, 3) != 0) ? {4'h0, 4'($urandom_range(0, 15))} : 8'($urandom);
      r = int'($urandom_range(0, 99));
      tb_byte.push_back(b);
      tb_kind.push_back((r < 10) ? 1 : ((par_en && r < 25) ? 2 : 0));
      tb_gap.push_back(($urandom_range(0, 6) == 0) ? int'($urandom_range(100, 140))
                                                   : int'($urandom_range(0, 10)));
    end
  endtask

  task automatic play(input bit par_en);
    foreach (tb_byte[i]) begin
      send_frame(tb_byte[i], par_en, tb_kind[i] == 2 || (tb_kind[i] == 1 && tb_byte[i][0]),
                 tb_kind[i] == 1);
      rx = 1'b1;
      tick(tb_gap[i]);
    end
    tick(5);
  endtask

  // Protocol-level model: bytes pair up as {nibble, low}; errors reset pairing.
  task automatic run_model();
    bit         lo;
    logic [3:0] nib;
    lo = 1'b0;
    nib = 4'h0;
    exp_q.delete();
    exp_fe = 0; exp_pe = 0; exp_se = 0;
    foreach (tb_byte[i]) begin
      if (tb_kind[i] == 1) begin
        exp_fe++;
        lo = 1'b0;
      end else if (tb_kind[i] == 2) begin
        exp_pe++;
        lo = 1'b0;
      end else if (!lo) begin
        if (tb_byte[i][7:4] == 4'h0) begin
          nib = tb_byte[i][3:0];
          lo = 1'b1;
        end else begin
          exp_se++;
        end
      end else begin
        exp_q.push_back({nib, tb_byte[i]});
        lo = 1'b0;
      end
      if (lo && tb_gap[i] > GAP) begin
        exp_se++;
        lo = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    tick(3);
    vectors++;
    if ({d0_sample, d0_valid, d0_fe, d0_pe, d0_se, d0_busy} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_dut0: got %h required 0",
               {d0_sample, d0_valid, d0_fe, d0_pe, d0_se, d0_busy});
    end
    vectors++;
    if ({d1_sample, d1_valid, d1_fe, d1_pe, d1_se, d1_busy} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %h required 0",
               {d1_sample, d1_valid, d1_fe, d1_pe, d1_se, d1_busy});
    end
    reset = 1'b1;
    clear_obs();
    tick(10);
    vectors++;
    if (busy_cnt + fe0 + pe0 + se0 + got0.size() != 0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %0d events required 0",
               busy_cnt + fe0 + pe0 + se0 + got0.size());
    end
  endtask

  task automatic test_pair();
    do_reset();
    send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
    send_frame(8'hBC, 1'b0, 1'b0, 1'b0);
    tick(10);
    vectors++;
    if (got0.size() != 1) begin
      miscompares++;
      $display("FAIL pair_count: got %0d required 1", got0.size());
    end
    if (got0.size() > 0) begin
      vectors++;
      if (got0[0] !== 12'hABC) begin
        miscompares++;
        $display("FAIL pair_value: got %h required abc", got0[0]);
      end
    end
    vectors++;
    if (fe0 + pe0 + se0 != 0) begin
      miscompares++;
      $display("FAIL pair_errors: got %0d required 0", fe0 + pe0 + se0);
    end
    vectors++;
    if (sv_cyc0 - stop_cyc != 3 + BAUD / 2) begin
      miscompares++;
      $display("FAIL pair_latency: got %0d required %0d", sv_cyc0 - stop_cyc, 3 + BAUD / 2);
    end
    vectors++;
    if (busy_cnt != 2 * (BAUD / 2 + 9 * BAUD)) begin
      miscompares++;
      $display("FAIL pair_busy_cycles: got %0d required %0d", busy_cnt,
               2 * (BAUD / 2 + 9 * BAUD));
    end
  endtask

  task automatic test_sync_high();
    do_reset();
    send_frame(8'hF1, 1'b0, 1'b0, 1'b0);
    tick(2);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0);
    tick(2);
    send_frame(8'h45, 1'b0, 1'b0, 1'b0);
    tick(30);
    vectors++;
    if (se0 != 1 || fe0 + pe0 != 0) begin
      miscompares++;
      $display("FAIL sync_high_errors: got se=%0d fe+pe=%0d required 1/0", se0, fe0 + pe0);
    end
    vectors++;
    if (got0.size() != 1 || (got0.size() > 0 && got0[0] !== 12'h345)) begin
      miscompares++;
      $display("FAIL sync_high_sample: got %0d samples required one 345", got0.size());
    end
    vectors++;
    if (d0_sample !== 12'h345) begin
      miscompares++;
      $display("FAIL sync_high_hold: got %h required 345", d0_sample);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_frame(8'h05, 1'b0, 1'b0, 1'b1);
    tick(3);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0, 1'b0);
    tick(10);
    vectors++;
    if (fe0 != 1 || pe0 + se0 != 0) begin
      miscompares++;
      $display("FAIL framing_errors: got fe=%0d pe+se=%0d required 1/0", fe0, pe0 + se0);
    end
    vectors++;
    if (got0.size() != 1 || (got0.size() > 0 && got0[0] !== 12'h123)) begin
      miscompares++;
      $display("FAIL framing_sample: got %0d samples required one 123", got0.size());
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h0A, 1'b1, 1'b1, 1'b0);
    tick(3);
    vectors++;
    if (pe1 != 1 || got1.size() != 0) begin
      miscompares++;
      $display("FAIL parity_bad: got pe=%0d samples=%0d required 1/0", pe1, got1.size());
    end
    send_frame(8'h0A, 1'b1, 1'b0, 1'b0);
    send_frame(8'hBC, 1'b1, 1'b0, 1'b0);
    tick(10);
    vectors++;
    if (got1.size() != 1 || (got1.size() > 0 && got1[0] !== 12'hABC)) begin
      miscompares++;
      $display("FAIL parity_sample: got %0d samples required one abc", got1.size());
    end
    vectors++;
    if (pe1 != 1 || fe1 + se1 != 0) begin
      miscompares++;
      $display("FAIL parity_errors: got pe=%0d fe+se=%0d required 1/0", pe1, fe1 + se1);
    end
  endtask

  task automatic test_gap();
    do_reset();
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    tick(100);
    vectors++;
    if (se0 != 1 || got0.size() != 0) begin
      miscompares++;
      $display("FAIL gap_timeout: got se=%0d samples=%0d required 1/0", se0, got0.size());
    end
    send_frame(8'h08, 1'b0, 1'b0, 1'b0);
    send_frame(8'h9F, 1'b0, 1'b0, 1'b0);
    tick(10);
    vectors++;
    if (got0.size() != 1 || (got0.size() > 0 && got0[0] !== 12'h89F) || se0 != 1) begin
      miscompares++;
      $display("FAIL gap_sample: got %0d samples se=%0d required one 89f, se=1",
               got0.size(), se0);
    end
  endtask

  task automatic test_glitch_reset();
    logic [7:0] b;
    clear_obs();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(8);
    vectors++;
    if (busy_cnt != 1 || fe0 + pe0 + se0 + got0.size() != 0) begin
      miscompares++;
      $display("FAIL glitch: got busy=%0d events=%0d required 1/0", busy_cnt,
               fe0 + pe0 + se0 + got0.size());
    end
    b = 8'h0F;
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = b[4];
    tick(1);
    vectors++;
    if (d0_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: got %b required 1", d0_busy);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({d0_sample, d0_valid, d0_fe, d0_pe, d0_se, d0_busy} !== 17'h0) begin
      miscompares++;
      $display("FAIL midframe_reset: got %h required 0",
               {d0_sample, d0_valid, d0_fe, d0_pe, d0_se, d0_busy});
    end
    rx = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_obs();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    tick(10);
    vectors++;
    if (got0.size() != 1 || (got0.size() > 0 && got0[0] !== 12'hFFF) ||
        fe0 + pe0 + se0 != 0) begin
      miscompares++;
      $display("FAIL post_reset_sample: got %0d samples errors=%0d required one fff",
               got0.size(), fe0 + pe0 + se0);
    end
  endtask

  task automatic test_random(input bit par_en, input int n);
    do_reset();
    gen(par_en, n);
    play(par_en);
    run_model();
    if (par_en) begin
      vectors++;
      if (got1.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_par_count: got %0d required %0d", got1.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got1.size(); i++) begin
        vectors++;
        if (got1[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_par_sample[%0d]: got %h required %h", i, got1[i], exp_q[i]);
        end
      end
      vectors++;
      if (fe1 != exp_fe || pe1 != exp_pe || se1 != exp_se) begin
        miscompares++;
        $display("FAIL rand_par_errors: got %0d/%0d/%0d required %0d/%0d/%0d",
                 fe1, pe1, se1, exp_fe, exp_pe, exp_se);
      end
    end else begin
      vectors++;
      if (got0.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_count: got %0d required %0d", got0.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got0.size(); i++) begin
        vectors++;
        if (got0[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_sample[%0d]: got %h required %h", i, got0[i], exp_q[i]);
        end
      end
      vectors++;
      if (fe0 != exp_fe || pe0 != exp_pe || se0 != exp_se) begin
        miscompares++;
        $display("FAIL rand_errors: got %0d/%0d/%0d required %0d/%0d/%0d",
                 fe0, pe0, se0, exp_fe, exp_pe, exp_se);
      end
    end
    vectors++;
    if (multi_cnt != 0) begin
      miscompares++;
      $display("FAIL rand_one_pulse: got %0d overlapping cycles required 0", multi_cnt);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_pair();
    test_sync_high();
    test_framing();
    test_parity();
    test_gap();
    test_glitch_reset();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
